// File: rtl/turing_pkg.sv
// turing_pkg: shared encodings for the programmable Turing machine engine.
//   status_e : run result reported on turing_engine.status
//   move_e   : head move direction stored in a table entry
//   ctrl_e   : control FSM states (idle / running)
//   ent_*    : bit positions of the fields inside a table entry, as a
//              function of the machine-state width SW. An entry is laid out
//              as {halt, wbit, move, next_state[SW-1:0]}.
package turing_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_HALT = 2'b01,
      ST_OOB  = 2'b10,
      ST_TMO  = 2'b11
   } status_e;

   typedef enum logic {
      MV_L = 1'b0,
      MV_R = 1'b1
   } move_e;

   typedef enum logic {
      CT_IDLE = 1'b0,
      CT_RUN  = 1'b1
   } ctrl_e;

   function automatic int unsigned ent_move_pos(input int unsigned sw);
      return sw;
   endfunction

   function automatic int unsigned ent_wbit_pos(input int unsigned sw);
      return sw + 1;
   endfunction

   function automatic int unsigned ent_halt_pos(input int unsigned sw);
      return sw + 2;
   endfunction

   function automatic int unsigned ent_width(input int unsigned sw);
      return sw + 3;
   endfunction

endpackage

// File: rtl/turing_table.sv
// turing_table: transition table register file, 2**(SW+1) entries of EW bits,
// indexed by {state, symbol}. Asynchronously cleared to all-zero entries,
// written synchronously, read combinationally.
//   clk_i    : clock, rising edge
//   rstn_i   : asynchronous active-low reset (clears every entry)
//   we_i     : write strobe
//   waddr_i  : write index {state, symbol}
//   wdata_i  : entry to write
//   raddr_i  : read index {state, symbol}
//   rdata_o  : entry at raddr_i
module turing_table #(
   parameter int unsigned SW = 2,
   parameter int unsigned EW = SW + 3
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          we_i,
   input  logic [SW:0]   waddr_i,
   input  logic [EW-1:0] wdata_i,
   input  logic [SW:0]   raddr_i,
   output logic [EW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** (SW + 1);

   logic [EW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/turing_engine.sv
// turing_engine: programmable single-tape binary Turing machine.
// A transition table is loaded while idle; a start pulse loads the tape and
// head, then one transition executes per clock until a halt entry, a move off
// the tape edge, or (optionally) the step limit.
// Optional feature macro: TURING_TIMEOUT_EN enables the MAX_STEPS limit
// (status 11); without it the step counter saturates and runs are unbounded.
// Ports:
//   clk, rstn            : clock (rising edge), async active-low reset
//   prog_we/addr/data    : table write port, entry {halt, wbit, move, next}
//   start                : run request pulse (ignored while busy)
//   tape_in, head_in     : initial tape and head, sampled on accepted start
//   busy, done, status   : run in progress / run finished / result code
//   tape_out, head, steps: live tape, head position and transition count
module turing_engine #(
   parameter  int unsigned TAPE_W    = 16,
   parameter  int unsigned NSTATE    = 4,
   parameter  int unsigned STEP_W    = 16,
   parameter  int unsigned MAX_STEPS = 1000,
   localparam int unsigned SW        = $clog2(NSTATE),
   localparam int unsigned HW        = $clog2(TAPE_W)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              prog_we,
   input  logic [SW:0]       prog_addr,
   input  logic [SW+2:0]     prog_data,
   input  logic              start,
   input  logic [TAPE_W-1:0] tape_in,
   input  logic [HW-1:0]     head_in,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [TAPE_W-1:0] tape_out,
   output logic [HW-1:0]     head,
   output logic [STEP_W-1:0] steps
);

   import turing_pkg::*;

   localparam int unsigned EW     = ent_width(SW);
   localparam int unsigned P_MOVE = ent_move_pos(SW);
   localparam int unsigned P_WBIT = ent_wbit_pos(SW);
   localparam int unsigned P_HALT = ent_halt_pos(SW);

   localparam logic [HW-1:0]     HEAD_ONE = HW'(1);
   localparam logic [HW-1:0]     HEAD_MAX = HW'(TAPE_W - 1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(MAX_STEPS);

`ifdef TURING_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   ctrl_e             ctrl_q;
   logic [SW-1:0]     mstate_q, mstate_d;
   logic [TAPE_W-1:0] tape_q, tape_d;
   logic [HW-1:0]     head_q, head_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   status_e           status_q, status_d;
   logic              busy_q, done_q;

   logic [EW-1:0]     ent;
   logic              sym;
   move_e             e_move;
   logic              oob;
   logic              stop;
   logic              tbl_we;

   // Writes are only honoured while idle so a running program never changes.
   assign tbl_we = prog_we & (ctrl_q == CT_IDLE);
   assign sym    = tape_q[head_q];

   turing_table #(
      .SW (SW),
      .EW (EW)
   ) u_table (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .we_i    (tbl_we),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i ({mstate_q, sym}),
      .rdata_o (ent)
   );

   // One transition: the symbol write and step count always happen; the
   // terminating conditions are prioritised halt > edge fault > step limit.
   always_comb begin
      e_move          = move_e'(ent[P_MOVE]);
      oob             = ((e_move == MV_L) && (head_q == '0)) ||
                        ((e_move == MV_R) && (head_q == HEAD_MAX));
      tape_d          = tape_q;
      tape_d[head_q]  = ent[P_WBIT];
      steps_d         = (steps_q == '1) ? steps_q : steps_q + STEP_ONE;
      head_d          = head_q;
      mstate_d        = mstate_q;
      status_d        = ST_NONE;
      stop            = 1'b0;
      if (ent[P_HALT]) begin
         status_d = ST_HALT;
         stop     = 1'b1;
      end else if (oob) begin
         status_d = ST_OOB;
         stop     = 1'b1;
      end else begin
         head_d   = (e_move == MV_R) ? head_q + HEAD_ONE : head_q - HEAD_ONE;
         mstate_d = ent[SW-1:0];
         if (TMO_EN && (steps_d == STEP_LIM)) begin
            status_d = ST_TMO;
            stop     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl_q   <= CT_IDLE;
         mstate_q <= '0;
         tape_q   <= '0;
         head_q   <= '0;
         steps_q  <= '0;
         status_q <= ST_NONE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (ctrl_q)
            CT_IDLE: begin
               if (start) begin
                  tape_q   <= tape_in;
                  head_q   <= head_in;
                  mstate_q <= '0;
                  steps_q  <= '0;
                  status_q <= ST_NONE;
                  done_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  ctrl_q   <= CT_RUN;
               end
            end
            CT_RUN: begin
               tape_q   <= tape_d;
               head_q   <= head_d;
               mstate_q <= mstate_d;
               steps_q  <= steps_d;
               if (stop) begin
                  status_q <= status_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  ctrl_q   <= CT_IDLE;
               end
            end
            default: ctrl_q <= CT_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign status   = status_q;
   assign tape_out = tape_q;
   assign head     = head_q;
   assign steps    = steps_q;

endmodule
